violet_panel_arbiter: RTL and testbench



---
 rtl/violet_panel_arbiter.sv | 178 +++++++++++++++++
 tb/tb_violet_panel_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/violet_panel_arbiter.sv
// Shares one violet I/O panel (leds/display/buttons) between up to 4 clients with manual and round-robin switching.
// Optional blanking on every ownership change is enabled with the VIOLET_ARB_BLANK_EN macro.
module violet_panel_arbiter #(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned HOLD_CYCLES  = 2500000,
  parameter int unsigned SEL_BTN      = 15,
  parameter int unsigned BLANK_CYCLES = 2500000
) (
  input  logic                      i_clk,
  input  logic                      rst,
  input  logic [15:0]               buttons,
  output logic [15:0]               leds,
  output logic [15:0]               display,
  input  logic [16*NUM_CLIENTS-1:0] cl_leds,
  input  logic [16*NUM_CLIENTS-1:0] cl_display,
  input  logic [NUM_CLIENTS-1:0]    cl_req,
  output logic [NUM_CLIENTS-1:0]    cl_grant,
  output logic [16*NUM_CLIENTS-1:0] cl_buttons,
  output logic [1:0]                owner
);

  localparam int unsigned DWELL_W = $clog2(HOLD_CYCLES + 2);
  localparam logic [15:0] SEL_MASK = ~(16'(1) << SEL_BTN);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 4 || SEL_BTN > 15 || BLANK_CYCLES == 0) begin : g_bad_param
    $error("violet_panel_arbiter: illegal parameter value");
  end

`ifdef VIOLET_ARB_BLANK_EN
  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
  typedef enum logic [0:0] {ST_HOLD, ST_BLANK} state_t;
`else
  typedef enum logic [0:0] {ST_HOLD} state_t;
`endif

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [1:0]                r_owner;
  logic [1:0]                w_owner_nxt;
  logic [1:0]                w_owner_inc;
  logic [NUM_CLIENTS-1:0]    r_grant;
  logic [DWELL_W-1:0]        r_dwell;
  logic [DWELL_W-1:0]        w_dwell_nxt;
  logic                      r_btn_prev;
  logic [15:0]               r_leds;
  logic [15:0]               r_display;
  logic [16*NUM_CLIENTS-1:0] r_cl_buttons;
  logic [15:0]               w_leds_nxt;
  logic [15:0]               w_display_nxt;
  logic [16*NUM_CLIENTS-1:0] w_cl_buttons_nxt;
  logic                      w_manual;
  logic                      w_auto;
  logic                      w_auto_hit;
  logic [1:0]                w_auto_idx;
  logic                      w_req_own;
  logic [NUM_CLIENTS-1:0]    w_req_sh;
  logic [NUM_CLIENTS-1:0]    w_req_own_sh;
  int                        w_scan;
  logic                      w_blank_out;
`ifdef VIOLET_ARB_BLANK_EN
  logic [BLANK_W-1:0]        r_blank;
  logic [BLANK_W-1:0]        w_blank_nxt;
`endif

  assign w_owner_inc  = (r_owner == 2'(NUM_CLIENTS - 1)) ? 2'd0 : r_owner + 2'd1;
  assign w_req_own_sh = cl_req >> r_owner;
  assign w_req_own    = w_req_own_sh[0];

  // Round-robin scan: descending loop so the nearest requester after the owner wins.
  always_comb begin
    w_auto_hit = 1'b0;
    w_auto_idx = r_owner;
    w_scan     = 0;
    w_req_sh   = '0;
    for (int i = int'(NUM_CLIENTS) - 1; i >= 1; i--) begin
      w_scan   = (int'(r_owner) + i) % int'(NUM_CLIENTS);
      w_req_sh = cl_req >> w_scan;
      if (w_req_sh[0]) begin
        w_auto_hit = 1'b1;
        w_auto_idx = 2'(w_scan);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) r_state <= ST_HOLD;
    else     r_state <= w_state_nxt;
  end

  // Next-state, owner and dwell logic; manual select takes priority over auto.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_dwell_nxt = r_dwell;
    w_manual    = 1'b0;
    w_auto      = 1'b0;
`ifdef VIOLET_ARB_BLANK_EN
    w_blank_nxt = r_blank;
`endif
    case (r_state)
      ST_HOLD: begin
        w_manual = buttons[SEL_BTN] & ~r_btn_prev;
        w_auto   = (r_dwell == DWELL_W'(HOLD_CYCLES)) & ~w_req_own & w_auto_hit;
        if (w_manual)    w_owner_nxt = w_owner_inc;
        else if (w_auto) w_owner_nxt = w_auto_idx;
        if (w_manual || w_auto) begin
          w_dwell_nxt = '0;
`ifdef VIOLET_ARB_BLANK_EN
          w_state_nxt = ST_BLANK;
          w_blank_nxt = BLANK_W'(BLANK_CYCLES - 1);
`endif
        end else if (r_dwell != DWELL_W'(HOLD_CYCLES)) begin
          w_dwell_nxt = r_dwell + DWELL_W'(1);
        end
      end
`ifdef VIOLET_ARB_BLANK_EN
      ST_BLANK: begin
        w_dwell_nxt = '0;
        if (r_blank == '0) w_state_nxt = ST_HOLD;
        else               w_blank_nxt = r_blank - BLANK_W'(1);
      end
`endif
      default: w_state_nxt = ST_HOLD;
    endcase
  end

`ifdef VIOLET_ARB_BLANK_EN
  assign w_blank_out = (w_state_nxt == ST_BLANK);
`else
  assign w_blank_out = 1'b0;
`endif

  // Panel words follow the current owner; buttons already follow the next owner.
  always_comb begin
    w_leds_nxt       = cl_leds[{r_owner, 4'b0000} +: 16];
    w_display_nxt    = cl_display[{r_owner, 4'b0000} +: 16];
    w_cl_buttons_nxt = '0;
    w_cl_buttons_nxt[{w_owner_nxt, 4'b0000} +: 16] = buttons & SEL_MASK;
    if (w_blank_out) begin
      w_leds_nxt       = '0;
      w_display_nxt    = '0;
      w_cl_buttons_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_owner      <= 2'd0;
      r_grant      <= NUM_CLIENTS'(1);
      r_dwell      <= '0;
      r_btn_prev   <= 1'b1;
      r_leds       <= '0;
      r_display    <= '0;
      r_cl_buttons <= '0;
`ifdef VIOLET_ARB_BLANK_EN
      r_blank      <= '0;
`endif
    end else begin
      r_owner      <= w_owner_nxt;
      r_grant      <= NUM_CLIENTS'(1) << w_owner_nxt;
      r_dwell      <= w_dwell_nxt;
      r_btn_prev   <= buttons[SEL_BTN];
      r_leds       <= w_leds_nxt;
      r_display    <= w_display_nxt;
      r_cl_buttons <= w_cl_buttons_nxt;
`ifdef VIOLET_ARB_BLANK_EN
      r_blank      <= w_blank_nxt;
`endif
    end
  end

  assign owner      = r_owner;
  assign cl_grant   = r_grant;
  assign leds       = r_leds;
  assign display    = r_display;
  assign cl_buttons = r_cl_buttons;

endmodule

// File: tb/tb_violet_panel_arbiter.sv
// Directed bench for violet_panel_arbiter: expected panel state is queued per cycle and checked after each edge.
module tb_violet_panel_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] buttons;
  logic [15:0] leds;
  logic [15:0] display;
  logic [63:0] cl_leds;
  logic [63:0] cl_display;
  logic [3:0]  cl_req;
  logic [3:0]  cl_grant;
  logic [63:0] cl_buttons;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  violet_panel_arbiter #(
    .NUM_CLIENTS (4),
    .HOLD_CYCLES (8),
    .SEL_BTN     (15),
    .BLANK_CYCLES(5)
  ) dut (
    .i_clk     (clk),
    .rst       (rst),
    .buttons   (buttons),
    .leds      (leds),
    .display   (display),
    .cl_leds   (cl_leds),
    .cl_display(cl_display),
    .cl_req    (cl_req),
    .cl_grant  (cl_grant),
    .cl_buttons(cl_buttons),
    .owner     (owner)
  );

  typedef struct {
    string       tag;
    logic [1:0]  owner;
    logic [3:0]  grant;
    logic [15:0] leds;
    logic [15:0] display;
    logic [63:0] btns;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] last_eo = 2'd0;
  string      cur_tag = "init";

  function automatic logic [15:0] word_of(input logic [63:0] packed_w, input logic [1:0] k);
    return packed_w[{k, 4'b0000} +: 16];
  endfunction

  task automatic chk(input string tag, input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s %s: got %h want %h", tag, name, obs, exp);
    end
  endtask

  // One clock: queue the expected outputs from the driven inputs, clock, then pop and compare.
  task automatic cyc(input logic [1:0] eo, input bit zero);
    exp_t e;
    e.tag     = cur_tag;
    e.owner   = eo;
    e.grant   = 4'(1) << eo;
    e.leds    = zero ? 16'h0 : word_of(cl_leds, last_eo);
    e.display = zero ? 16'h0 : word_of(cl_display, last_eo);
    e.btns    = '0;
    if (!zero) e.btns[{eo, 4'b0000} +: 16] = buttons & 16'h7FFF;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk(e.tag, "owner", 64'(owner), 64'(e.owner));
    chk(e.tag, "grant", 64'(cl_grant), 64'(e.grant));
    chk(e.tag, "leds", 64'(leds), 64'(e.leds));
    chk(e.tag, "display", 64'(display), 64'(e.display));
    chk(e.tag, "cl_buttons", cl_buttons, e.btns);
    last_eo = eo;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2'd0, 1'b1);
    cyc(2'd0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    buttons    = 16'h0000;
    cl_req     = 4'b0000;
    cl_leds    = {16'h3333, 16'h2222, 16'h8000, 16'h0001};
    cl_display = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

    cur_tag = "reset";
    do_reset();
    buttons = 16'h0F0F;
    cyc(2'd0, 1'b0);
    cyc(2'd0, 1'b0);

`ifndef VIOLET_ARB_BLANK_EN
    cur_tag = "manual";
    buttons = 16'hC000;
    cyc(2'd1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(2'd1, 1'b0);
    buttons = 16'h0000;
    cyc(2'd1, 1'b0);
    cyc(2'd1, 1'b0);

    cur_tag = "auto_rr";
    cl_req = 4'b1010;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(2'd0, 1'b0);
    cyc(2'd1, 1'b0);
    cl_req = 4'b1000;
    for (int i = 0; i < 8; i++) cyc(2'd1, 1'b0);
    cyc(2'd3, 1'b0);
    cl_req = 4'b0000;
    for (int i = 0; i < 12; i++) cyc(2'd3, 1'b0);

    cur_tag = "owner_req";
    cl_req = 4'b1111;
    do_reset();
    for (int i = 0; i < 24; i++) cyc(2'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      buttons = 16'h8000;
      cyc(2'(k), 1'b0);
      buttons = 16'h0000;
      cyc(2'(k), 1'b0);
    end

    cur_tag = "simul";
    cl_req = 4'b0100;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(2'd0, 1'b0);
    buttons = 16'h8000;
    cyc(2'd1, 1'b0);
    buttons = 16'h0000;
    cl_req  = 4'b0000;
    cyc(2'd1, 1'b0);
`else
    cur_tag = "blank";
    buttons = 16'h8000;
    cyc(2'd1, 1'b1);
    buttons = 16'h0000;
    for (int i = 0; i < 3; i++) cyc(2'd1, 1'b1);
    buttons = 16'h8000;
    cyc(2'd1, 1'b1);
    cyc(2'd1, 1'b0);
    buttons = 16'h0000;
    cyc(2'd1, 1'b0);

    cur_tag = "blank_rst";
    do_reset();
    buttons = 16'h8000;
    cyc(2'd1, 1'b1);
    buttons = 16'h0000;
    cyc(2'd1, 1'b1);
    cyc(2'd1, 1'b1);
    do_reset();
    buttons = 16'h0101;
    cyc(2'd0, 1'b0);
    cyc(2'd0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
